ffd_bank_arbiter: RTL
=====================

// Module: ffd_bank_arbiter
// PURPOSE
//   Round-robin arbiter sharing one WIDTH-bit register bank (D flops with clear/set/enable) among N_REQ requesters.
//   Each granted requester issues one command: load data, set all bits, or clear all bits.
//   Sequences the bank's clear/set/enable controls and reports completion with a one-cycle done pulse.
//   Sits between the requester blocks and the shared state register.
// PARAMETERS
//   N_REQ   4   number of requesters (>=2)
//   WIDTH   8   bank width in bits
// PORTS
//   clk       in   1             single clock; all state changes on rising edge
//   reset_n   in   1             asynchronous, active-low reset
//   req       in   N_REQ         request, one bit per requester
//   cmd       in   2*N_REQ       per-requester command [2i+1:2i]: 00 LOAD, 01 SET_ALL, 10 CLR_ALL, 11 NOP
//   wdata     in   WIDTH*N_REQ   per-requester load data [WIDTH*i +: WIDTH]
//   lock      in   N_REQ         hold-bank request (used only with FFD_ARB_LOCK_EN)
//   gnt       out  N_REQ         one-hot grant
//   done      out  N_REQ         one-cycle completion pulse for the granted requester
//   owner     out  $clog2(N_REQ) index of current/last grantee
//   busy      out  1             high whenever state != IDLE
//   bank_q    out  WIDTH         bank contents
// BEHAVIOUR
//   Reset (reset_n low, any time, incl. mid-operation): state=IDLE, gnt=0, done=0, busy=0, owner=0, rr pointer=0, bank_q=0.
//   FSM: IDLE -> APPLY -> DONE -> IDLE; one operation every 3 cycles.
//   IDLE: if any req, at edge E0 pick first set req at or after rr pointer (wrapping); register gnt, owner, cmd, wdata; go APPLY.
//     Command/data latched at E0; requester inputs are don't-care afterwards.
//   APPLY: drive bank with latched command for one cycle; bank updates at edge E1; go DONE.
//     Bank control priority clear > set > enable; NOP drives none (bank holds).
//   DONE: done[owner]=1, gnt still held, bank_q already shows new value; at E2 gnt=0, rr pointer=owner+1 mod N_REQ, go IDLE.
//   Latency: req seen at E0 -> done visible in the cycle after E1 -> new value on bank_q in the same cycle.
//   req held high through DONE is re-arbitrated in IDLE as a new request (rr pointer already advanced, so others win first).
//   req dropped during APPLY/DONE: operation still completes, done still pulses.
//   No req in IDLE: all outputs hold, bank holds.
//   gnt and done are always zero or one-hot; done never asserts outside DONE.
// CONFIGURATION
//   FFD_ARB_LOCK_EN defined: if lock[owner]=1 in DONE, at E2 go to IDLE with rr pointer NOT advanced and
//     arbitration restricted to owner until a DONE with lock[owner]=0; while locked, other requests wait; busy stays 1.
//   FFD_ARB_LOCK_EN undefined: lock port present but ignored; pure round-robin as above.
// STRUCTURE
//   Package ffd_arb_pkg: cmd encodings (CMD_LOAD, CMD_SET_ALL, CMD_CLR_ALL, CMD_NOP), FSM state typedef.
//   Sub-module ffd_bank: WIDTH flops with async reset_n, sync clear/set/enable, priority clear>set>enable.
//   Top: rr pointer, arbitration, FSM, latch registers, ffd_bank instance.
// TESTING
//   Reset released, no req -> gnt=0, busy=0, bank_q=8'h00 for 10 cycles.
//   req=0001 cmd0=LOAD wdata0=8'hA5 -> gnt=0001 at E0, bank_q=8'hA5 and done=0001 in the cycle after E1, gnt=0 after E2.
//   req=1111 held constant, all LOAD distinct data -> grants in order 0,1,2,3,0; each done matches its grant.
//   req0 SET_ALL then req1 CLR_ALL -> bank_q 8'hFF then 8'h00; NOP from req2 -> bank_q unchanged, done still pulses.
//   reset_n pulsed low during APPLY -> gnt=0, done never pulses, bank_q=8'h00, next grant starts at requester 0.
//   FFD_ARB_LOCK_EN, req=0011, lock0=1 for 2 ops -> grants 0,0,0 then 1; without macro -> 0,1,0,1.

Source files
------------

// File: rtl/ffd_arb_pkg.sv
// rtl/ffd_arb_pkg.sv - shared command encodings and FSM state type for the bank arbiter
// Purpose: per-requester command codes and the arbiter FSM state enum.
// Ports: none (package).
package ffd_arb_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD    = 2'b00,
    CMD_SET_ALL = 2'b01,
    CMD_CLR_ALL = 2'b10,
    CMD_NOP     = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/ffd_bank.sv
// rtl/ffd_bank.sv - WIDTH-bit register bank with synchronous clear/set/enable
// Purpose: shared state register; clear wins over set, set wins over enable.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (bank -> 0)
//   clr, set, en   synchronous controls (priority clr > set > en)
//   d              load data used when en is the winning control
//   q              bank contents
module ffd_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             set,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (clr)  q <= '0;
    else if (set)  q <= '1;
    else if (en)   q <= d;
  end

endmodule

// File: rtl/ffd_bank_arbiter.sv
// rtl/ffd_bank_arbiter.sv - round-robin arbiter sequencing a shared register bank
// Purpose: grants one requester at a time (IDLE -> APPLY -> DONE), applies its
//   LOAD/SET_ALL/CLR_ALL/NOP command to the bank and pulses done for it.
// Optional feature macro: FFD_ARB_LOCK_EN (lock[owner] in DONE keeps the bank
//   reserved for the owner; without it the lock port is ignored).
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   req            request per requester
//   cmd            per-requester command [2i+1:2i]
//   wdata          per-requester load data [WIDTH*i +: WIDTH]
//   lock           per-requester hold-bank request
//   gnt            one-hot grant, held through APPLY and DONE
//   done           one-cycle completion pulse in DONE
//   owner          index of current/last grantee
//   busy           high while an operation runs or the bank is locked
//   bank_q         bank contents
module ffd_bank_arbiter
  import ffd_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       cmd,
  input  logic [WIDTH*N_REQ-1:0]   wdata,
  input  logic [N_REQ-1:0]         lock,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic [WIDTH-1:0]         bank_q
);

  localparam int OW = $clog2(N_REQ);

  state_e             state;
  logic [OW-1:0]      rr_ptr;
  cmd_e               cmd_q;
  logic [WIDTH-1:0]   wdata_q;
  logic               locked;

  logic [N_REQ-1:0]   lock_eff;
  logic [N_REQ-1:0]   cand;
  logic               found;
  logic [OW-1:0]      pick;
  logic [1:0]         pick_cmd;
  logic [WIDTH-1:0]   pick_data;

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

`ifdef FFD_ARB_LOCK_EN
  assign lock_eff = lock;
`else
  // Lock requests are masked off so the arbiter stays pure round-robin.
  assign lock_eff = lock & {N_REQ{1'b0}};
`endif

  // While locked only the owner may be granted; others wait.
  assign cand = locked ? (req & onehot(owner)) : req;

  // First candidate at or after the rr pointer, wrapping.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_cmd  = CMD_NOP;
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && cand[idx]) begin
        found     = 1'b1;
        pick      = OW'(idx);
        pick_cmd  = cmd[2*idx +: 2];
        pick_data = wdata[WIDTH*idx +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      done    <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      cmd_q   <= CMD_NOP;
      wdata_q <= '0;
      locked  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            gnt     <= onehot(pick);
            owner   <= pick;
            cmd_q   <= cmd_e'(pick_cmd);
            wdata_q <= pick_data;
            state   <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          // Bank updates on this edge, so done and the new value appear together.
          done  <= gnt;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= '0;
          gnt   <= '0;
          state <= ST_IDLE;
          if (lock_eff[owner]) begin
            locked <= 1'b1;
          end else begin
            locked <= 1'b0;
            rr_ptr <= (owner == OW'(N_REQ - 1)) ? '0 : owner + OW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE) || locked;

  logic bank_clr, bank_set, bank_en;
  assign bank_clr = (state == ST_APPLY) && (cmd_q == CMD_CLR_ALL);
  assign bank_set = (state == ST_APPLY) && (cmd_q == CMD_SET_ALL);
  assign bank_en  = (state == ST_APPLY) && (cmd_q == CMD_LOAD);

  ffd_bank #(.WIDTH(WIDTH)) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bank_clr),
    .set     (bank_set),
    .en      (bank_en),
    .d       (wdata_q),
    .q       (bank_q)
  );

endmodule
